// File: rtl/band_mixer.sv
// band_mixer: final EQ mix ahead of the speaker driver; one band per clock
// MAC for left and right, then master volume, 16-bit saturation and a vld strobe.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   smpl_vld                new band set offered (sampled each clk)
//   lft_bands, rght_bands   NUM_BANDS packed signed 16-bit band samples
//   gains                   NUM_BANDS packed signed GAIN_W gains (shared)
//   volume                  unsigned master volume
//   lft_chnnl, rght_chnnl   signed saturated mixed samples
//   vld                     1-clk strobe, outputs updated
//   busy                    set being processed (state != IDLE)
//   ovr                     strobe: smpl_vld dropped while busy
module band_mixer #(
   parameter int NUM_BANDS = 5,
   parameter int GAIN_W    = 13,
   parameter int GAIN_FRAC = 10,
   parameter int VOL_W     = 13,
   parameter int VOL_FRAC  = 12
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        smpl_vld,
   input  logic [16*NUM_BANDS-1:0]     lft_bands,
   input  logic [16*NUM_BANDS-1:0]     rght_bands,
   input  logic [GAIN_W*NUM_BANDS-1:0] gains,
   input  logic [VOL_W-1:0]            volume,
   output logic signed [15:0]          lft_chnnl,
   output logic signed [15:0]          rght_chnnl,
   output logic                        vld,
   output logic                        busy,
   output logic                        ovr
);

   localparam int IW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
   localparam int PW = 16 + GAIN_W;
   localparam int SW = 48;
   localparam logic [IW-1:0] LAST = IW'(NUM_BANDS - 1);
   localparam logic signed [SW-1:0] SMAX = 48'sd32767;
   localparam logic signed [SW-1:0] SMIN = -48'sd32768;

   typedef enum logic [1:0] {IDLE, ACC, VOL, OUT} state_t;

   state_t state, state_nxt;

   logic signed [15:0]       lb_sh [NUM_BANDS];
   logic signed [15:0]       rb_sh [NUM_BANDS];
   logic signed [GAIN_W-1:0] g_sh  [NUM_BANDS];
   logic [VOL_W-1:0]         vol_sh;

   logic [IW-1:0]      idx;
   logic signed [31:0] acc_l, acc_r;
   logic signed [SW-1:0] scl_l, scl_r;

   logic signed [PW-1:0]  prod_l, prod_r;
   logic signed [31:0]    term_l, term_r;
   logic signed [VOL_W:0] vol_s;
   logic signed [SW-1:0]  mul_l, mul_r;

   function automatic logic signed [15:0] sat16(
      input logic signed [SW-1:0] x
   );
      if (x > SMAX)
         return 16'sh7fff;
      else if (x < SMIN)
         return 16'sh8000;
      else
         return x[15:0];
   endfunction

   // Full-precision band products; >>> floors toward -inf.
   assign prod_l = lb_sh[idx] * g_sh[idx];
   assign prod_r = rb_sh[idx] * g_sh[idx];
   assign term_l = 32'(prod_l >>> GAIN_FRAC);
   assign term_r = 32'(prod_r >>> GAIN_FRAC);

   // Zero-extended volume keeps the multiply signed.
   assign vol_s = {1'b0, vol_sh};
   assign mul_l = SW'(acc_l) * SW'(vol_s);
   assign mul_r = SW'(acc_r) * SW'(vol_s);

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (smpl_vld) state_nxt = ACC;
         ACC:  if (idx == LAST) state_nxt = VOL;
         VOL:  state_nxt = OUT;
         OUT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_BANDS; i++) begin
            lb_sh[i] <= '0;
            rb_sh[i] <= '0;
            g_sh[i]  <= '0;
         end
         vol_sh     <= '0;
         idx        <= '0;
         acc_l      <= '0;
         acc_r      <= '0;
         scl_l      <= '0;
         scl_r      <= '0;
         lft_chnnl  <= '0;
         rght_chnnl <= '0;
         vld        <= 1'b0;
         ovr        <= 1'b0;
      end else begin
         vld <= (state == OUT);
         ovr <= smpl_vld && (state != IDLE);
         unique case (state)
            IDLE: begin
               if (smpl_vld) begin
                  for (int i = 0; i < NUM_BANDS; i++) begin
                     lb_sh[i] <= lft_bands[16*i +: 16];
                     rb_sh[i] <= rght_bands[16*i +: 16];
                     g_sh[i]  <= gains[GAIN_W*i +: GAIN_W];
                  end
                  vol_sh <= volume;
                  idx    <= '0;
                  acc_l  <= '0;
                  acc_r  <= '0;
               end
            end
            ACC: begin
               acc_l <= acc_l + term_l;
               acc_r <= acc_r + term_r;
               idx   <= idx + 1'b1;
            end
            VOL: begin
               scl_l <= mul_l >>> VOL_FRAC;
               scl_r <= mul_r >>> VOL_FRAC;
            end
            OUT: begin
               lft_chnnl  <= sat16(scl_l);
               rght_chnnl <= sat16(scl_r);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_band_mixer.sv
// tb_band_mixer: randomized scoreboard bench for band_mixer.
// Driver predicts accepts/drops; negedge monitor checks every cycle.
module tb_band_mixer;

   localparam int N  = 5;
   localparam int GW = 13;
   localparam int VW = 13;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic smpl_vld = 1'b0;
   logic [16*N-1:0] lft_bands = '0;
   logic [16*N-1:0] rght_bands = '0;
   logic [GW*N-1:0] gains = '0;
   logic [VW-1:0]   volume = '0;
   logic signed [15:0] lft_chnnl, rght_chnnl;
   logic vld, busy, ovr;

   band_mixer #(.NUM_BANDS(N)) dut (
      .clk(clk), .rst_n(rst_n), .smpl_vld(smpl_vld),
      .lft_bands(lft_bands), .rght_bands(rght_bands),
      .gains(gains), .volume(volume),
      .lft_chnnl(lft_chnnl), .rght_chnnl(rght_chnnl),
      .vld(vld), .busy(busy), .ovr(ovr)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint l;
      longint r;
      int     due;
   } exp_t;

   exp_t   q[$];
   int     n_cmp = 0;
   int     n_bad = 0;
   int     cur_e = 0;
   int     last_acc = -1000;
   bit     exp_ovr = 1'b0;
   longint hold_l = 0;
   longint hold_r = 0;

   task automatic chk(input string nm, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, req, cur_e);
      end
   endtask

   function automatic longint floor_div(input longint a, input longint d);
      longint qt;
      qt = a / d;
      if ((a % d) != 0 && a < 0) qt = qt - 1;
      return qt;
   endfunction

   function automatic longint mix(input logic [16*N-1:0] b,
                                  input logic [GW*N-1:0] g,
                                  input logic [VW-1:0] v);
      longint acc, s;
      logic signed [15:0] bi;
      logic signed [GW-1:0] gi;
      acc = 0;
      for (int i = 0; i < N; i++) begin
         bi = b[16*i +: 16];
         gi = g[GW*i +: GW];
         acc += floor_div(longint'(bi) * longint'(gi), 1024);
      end
      s = floor_div(acc * longint'(v), 4096);
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return s;
   endfunction

   // One clock: model what the DUT does with the inputs sampled at this edge.
   task automatic step();
      exp_t e;
      @(posedge clk);
      cur_e++;
      exp_ovr = 1'b0;
      if (rst_n && smpl_vld) begin
         if (cur_e - last_acc >= 8) begin
            e.l = mix(lft_bands, gains, volume);
            e.r = mix(rght_bands, gains, volume);
            e.due = cur_e + 7;
            q.push_back(e);
            last_acc = cur_e;
         end else begin
            exp_ovr = 1'b1;
         end
      end
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      smpl_vld = 1'b0;
      last_acc = -1000;
      q.delete();
      hold_l = 0;
      hold_r = 0;
      exp_ovr = 1'b0;
      steps(2);
      rst_n = 1'b1;
   endtask

   task automatic rand_bands();
      for (int i = 0; i < N; i++) begin
         lft_bands[16*i +: 16]  = 16'($urandom);
         rght_bands[16*i +: 16] = 16'($urandom);
      end
   endtask

   task automatic rand_all();
      rand_bands();
      for (int i = 0; i < N; i++)
         gains[GW*i +: GW] = GW'($urandom);
      volume = VW'($urandom);
   endtask

   task automatic unity();
      for (int i = 0; i < N; i++)
         gains[GW*i +: GW] = 13'd1024;
      volume = 13'd4096;
   endtask

   task automatic one_set();
      smpl_vld = 1'b1;
      step();
      smpl_vld = 1'b0;
      steps(9);
   endtask

   always @(negedge clk) begin
      exp_t e;
      int d;
      d = cur_e - last_acc;
      chk("busy", longint'(busy), longint'(d >= 0 && d <= 6));
      chk("ovr", longint'(ovr), longint'(exp_ovr));
      if (vld) begin
         if (q.size() == 0) begin
            chk("vld_spurious", 1, 0);
         end else begin
            e = q.pop_front();
            chk("vld_time", cur_e, e.due);
            chk("lft", lft_chnnl, e.l);
            chk("rght", rght_chnnl, e.r);
            hold_l = e.l;
            hold_r = e.r;
         end
      end else begin
         if (q.size() > 0 && q[0].due <= cur_e) begin
            chk("vld_missing", 0, 1);
            void'(q.pop_front());
         end
         chk("hold_lft", lft_chnnl, hold_l);
         chk("hold_rght", rght_chnnl, hold_r);
      end
   end

   initial begin
      steps(2);
      rst_n = 1'b1;
      steps(2);

      // Single band through at unity.
      rand_bands();
      gains = '0;
      gains[GW-1:0] = 13'd1024;
      volume = 13'd4096;
      lft_bands[15:0]  = 16'd1000;
      rght_bands[15:0] = -16'sd1000;
      one_set();

      // Positive and negative saturation.
      unity();
      for (int i = 0; i < N; i++) begin
         lft_bands[16*i +: 16]  = 16'sd20000;
         rght_bands[16*i +: 16] = -16'sd20000;
      end
      one_set();
      for (int i = 0; i < N; i++) begin
         lft_bands[16*i +: 16]  = -16'sd20000;
         rght_bands[16*i +: 16] = 16'sd20000;
      end
      one_set();

      // Floor rounding of a negative product.
      lft_bands = '0;
      rght_bands = '0;
      gains = '0;
      lft_bands[15:0]  = -16'sd3;
      rght_bands[15:0] = 16'sd3;
      gains[GW-1:0] = 13'd512;
      volume = 13'd2048;
      one_set();

      // Overrun 3 clocks after acceptance.
      rand_all();
      smpl_vld = 1'b1;
      step();
      smpl_vld = 1'b0;
      steps(2);
      rand_all();
      smpl_vld = 1'b1;
      step();
      smpl_vld = 1'b0;
      steps(9);

      // Reset while accumulating band 2, then a clean set.
      rand_all();
      smpl_vld = 1'b1;
      step();
      smpl_vld = 1'b0;
      steps(2);
      do_reset();
      steps(10);
      rand_all();
      one_set();

      // smpl_vld held high with fresh data every cycle.
      unity();
      smpl_vld = 1'b1;
      for (int i = 0; i < 40; i++) begin
         rand_bands();
         step();
      end
      smpl_vld = 1'b0;
      steps(9);

      // Fully random traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         rand_all();
         smpl_vld = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 149) == 0)
            do_reset();
         else
            step();
      end
      smpl_vld = 1'b0;

      for (int i = 0; i < 20 && q.size() > 0; i++) step();
      chk("drain", q.size(), 0);
      steps(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
